// File: rtl/dma_pkg.sv
// Shared DMA definitions: default bus widths and the TX engine state encoding.
package dma_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ADDR_WIDTH = 8;
  localparam int unsigned SIZE_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } dma_tx_state_t;

endpackage

// File: rtl/dma_tx_controller.sv
// Memory-to-UART transmit DMA: reads a block from data memory one byte at a
// time and pushes each byte into the UART TX buffer, stalling while it is full.
module dma_tx_controller #(
  parameter int unsigned DATA_WIDTH = dma_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = dma_pkg::ADDR_WIDTH,
  parameter int unsigned SIZE_WIDTH = dma_pkg::SIZE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_address,
  input  logic [SIZE_WIDTH-1:0] transfer_size,
  output logic                  done,
  output logic                  busy,
  output logic                  mem_read_enable,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  uart_tx_write_enable,
  output logic [DATA_WIDTH-1:0] uart_tx_write_data,
  input  logic                  uart_tx_full
);

  import dma_pkg::*;

  dma_tx_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SIZE_WIDTH-1:0] remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
    end
  end

  // Next-state and register update decode
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          addr_d      = start_address;
          remaining_d = transfer_size;
          state_d     = (transfer_size == '0) ? DONE : READ;
        end
      end
      READ: begin
        state_d = WAIT;
      end
      WAIT: begin
        data_d  = mem_read_data;
        state_d = WRITE;
      end
      WRITE: begin
        if (!uart_tx_full) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          if (remaining_q != '0) begin
            remaining_d = remaining_q - SIZE_WIDTH'(1);
          end
          // A zero count here is unreachable; treat it as the last byte
          state_d = (remaining_q <= SIZE_WIDTH'(1)) ? DONE : READ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes come straight off the state register; the TX push also honours full
  assign done                 = (state_q == DONE);
  assign busy                 = (state_q == READ) || (state_q == WAIT) || (state_q == WRITE);
  assign mem_read_enable      = (state_q == READ);
  assign mem_read_address     = addr_q;
  assign uart_tx_write_enable = (state_q == WRITE) && !uart_tx_full;
  assign uart_tx_write_data   = data_q;

endmodule
